// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for pipelined_adder.
// The ovf signal exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
`ifdef PIPELINED_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
`ifdef PIPELINED_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_adder.sv
// N-bit adder pipelined as STAGES chunk-wide ripple adders with registered inter-chunk carry.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.

// One pipeline stage: adds the low chunk of the remaining operands, then shifts the
// operands down and inserts the chunk sum at the top of the accumulated sum, so after
// STAGES stages every chunk has landed in its final position.
module pipelined_adder_stage #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] sum_in,
    input  logic         cy_in,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic [N-1:0] sum_out,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic         ovf_out,
`endif
    output logic         cy_out
);
    logic [CHUNK:0] part;

    assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_in};

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the chunk MSB recovered from its sum bit; only the last stage's value is used.
    logic msb_cin;
    assign msb_cin = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ part[CHUNK-1];

    always_ff @(posedge clk) begin
        if (!rst_n)    ovf_out <= 1'b0;
        else if (load) ovf_out <= msb_cin ^ part[CHUNK];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out   <= '0;
            b_out   <= '0;
            sum_out <= '0;
            cy_out  <= 1'b0;
        end else if (load) begin
            a_out   <= a_in >> CHUNK;
            b_out   <= b_in >> CHUNK;
            sum_out <= (sum_in >> CHUNK) | (N'(part[CHUNK-1:0]) << (N - CHUNK));
            cy_out  <= part[CHUNK];
        end
    end
endmodule

module pipelined_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input logic             clk,
    input logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = N / STAGES;

    if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: N must be a multiple of STAGES and 1 <= STAGES <= N");
    end

    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] adv;
    logic [STAGES:0] cy_pipe;
    logic [N-1:0]    a_pipe   [STAGES+1];
    logic [N-1:0]    b_pipe   [STAGES+1];
    logic [N-1:0]    sum_pipe [STAGES+1];

    assign vld_pipe    = {vld_q, bus.in_valid};
    assign a_pipe[0]   = bus.a;
    assign b_pipe[0]   = bus.b;
    assign sum_pipe[0] = '0;
    assign cy_pipe[0]  = bus.c_in;

    // A stage may advance when it is empty or its successor advances, so bubbles collapse.
    always_comb begin
        adv         = '0;
        adv[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld_pipe[k+1] | adv[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) vld_q[k+1] <= vld_pipe[k];
            end
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic [STAGES:1] ovf_pipe;
    assign bus.ovf = ovf_pipe[STAGES];
`endif

    // Data registers load only with a valid token, so idle inputs never disturb held results.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_stage #(.N(N), .CHUNK(CHUNK)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (adv[k] & vld_pipe[k]),
            .a_in    (a_pipe[k]),
            .b_in    (b_pipe[k]),
            .sum_in  (sum_pipe[k]),
            .cy_in   (cy_pipe[k]),
            .a_out   (a_pipe[k+1]),
            .b_out   (b_pipe[k+1]),
            .sum_out (sum_pipe[k+1]),
`ifdef PIPELINED_ADDER_OVF_EN
            .ovf_out (ovf_pipe[k+1]),
`endif
            .cy_out  (cy_pipe[k+1])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = sum_pipe[STAGES];
    assign bus.c_out     = cy_pipe[STAGES];
endmodule
